// File: rtl/sw_color_pkg.sv
// Shared types for the slide-switch colour reader: colour encoding, reader FSM
// states and the legality check for a settled switch pattern.
package sw_color_pkg;

  typedef enum logic [2:0] {
    COLOR_OFF = 3'b000,
    COLOR_CH0 = 3'b001,
    COLOR_CH1 = 3'b010,
    COLOR_CH2 = 3'b100
  } color_t;

  typedef enum logic {
    S_IDLE,
    S_PEND
  } rd_state_t;

  // All switches off, or exactly one on; anything else is a user error.
  function automatic logic is_legal(color_t c);
    logic [2:0] v;
    v = c;
    return (v == COLOR_OFF) || (v == COLOR_CH0) ||
           (v == COLOR_CH1) || (v == COLOR_CH2);
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Vector synchronizer and debouncer: one shared hold counter for all bits, so
// the whole pattern must be constant for DEBOUNCE_CYCLES before it is accepted.
module sw_debounce
  import sw_color_pkg::*;
#(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] stable
);

  localparam int            CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sw_sync;
  logic [WIDTH-1:0] candidate;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= '0;
      sw_sync   <= '0;
      candidate <= '0;
      cnt       <= '0;
      stable    <= '0;
    end else begin
      sync_meta <= din;
      sw_sync   <= sync_meta;
      if (sw_sync != candidate) begin
        candidate <= sw_sync;
        cnt       <= '0;
      end else if (cnt == CNT_MAX) begin
        // Counter parks at terminal count; stable keeps tracking candidate.
        stable <= candidate;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sw_color_reader.sv
// Debounced switch-to-colour reader: classifies the settled switch pattern and
// offers each new legal colour downstream over a valid/ready handshake.
//
//   state  | meaning
//   S_IDLE | nothing offered, color_valid low
//   S_PEND | colour offered, waiting for color_ready (newer colour may be queued)
module sw_color_reader
  import sw_color_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic [2:0] SW,
  output logic [2:0] color,
  output logic       color_valid,
  input  logic       color_ready,
  output logic       error
);

  logic [2:0] stable;
  color_t     stable_c;
  logic       legal;
  logic       new_evt;
  logic       handshake;

  rd_state_t  state, state_d;
  color_t     color_q, color_d;
  color_t     last_color, last_d;
  color_t     newest, newest_d;
  logic       dirty, dirty_d;
  logic       valid_q, valid_d;
  logic       error_q;

  sw_debounce #(
    .WIDTH           (3),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (CLK100MHZ),
    .rst_n  (reset),
    .din    (SW),
    .stable (stable)
  );

  assign stable_c  = color_t'(stable);
  assign legal     = is_legal(stable_c);
  assign new_evt   = legal && (stable_c != last_color);
  assign handshake = valid_q && color_ready;

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      color_q    <= COLOR_OFF;
      valid_q    <= 1'b0;
      last_color <= COLOR_OFF;
      newest     <= COLOR_OFF;
      dirty      <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state      <= state_d;
      color_q    <= color_d;
      valid_q    <= valid_d;
      last_color <= last_d;
      newest     <= newest_d;
      dirty      <= dirty_d;
      error_q    <= !legal;
    end
  end

  always_comb begin
    state_d  = state;
    color_d  = color_q;
    valid_d  = valid_q;
    last_d   = last_color;
    newest_d = newest;
    dirty_d  = dirty;

    if (new_evt) last_d = stable_c;

    case (state)
      S_IDLE: begin
        if (new_evt) begin
          color_d = stable_c;
          valid_d = 1'b1;
          state_d = S_PEND;
        end
      end
      S_PEND: begin
        if (handshake) begin
          // A colour arriving in the handshake cycle outranks any queued one.
          if (new_evt) begin
            color_d = stable_c;
            dirty_d = 1'b0;
          end else if (dirty) begin
            color_d = newest;
            dirty_d = 1'b0;
          end else begin
            valid_d = 1'b0;
            state_d = S_IDLE;
          end
        end else if (new_evt) begin
          newest_d = stable_c;
          dirty_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign color       = color_q;
  assign color_valid = valid_q;
  assign error       = error_q;

endmodule

// File: tb/tb_sw_color_reader.sv
// Self-checking bench for sw_color_reader: per-scenario tasks with inline
// checks, plus a scoreboard of expected colours popped on each handshake.
module tb_sw_color_reader;
  import sw_color_pkg::*;

  localparam int DEB = 4;
  localparam int LAT = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] sw = 3'b000;
  logic       color_ready = 1'b0;
  logic [2:0] color;
  logic       color_valid;
  logic       error;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [2:0] exp_q[$];

  sw_color_reader #(.DEBOUNCE_CYCLES(DEB)) dut (
    .CLK100MHZ   (clk),
    .reset       (rst_n),
    .SW          (sw),
    .color       (color),
    .color_valid (color_valid),
    .color_ready (color_ready),
    .error       (error)
  );

  always #5 clk = ~clk;

  // Handshake monitor: every accepted colour must match the scoreboard head.
  always @(negedge clk) begin : mon
    logic [2:0] e;
    #1;
    if (rst_n && color_valid && color_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got color=%b, required no event", color);
      end else begin
        e = exp_q.pop_front();
        if (color !== e) begin
          n_fail++;
          $display("FAIL sb_color: got color=%b, required %b", color, e);
        end
      end
    end
  end

  // Edges from the sampling edge (index 0) until color_valid is seen high.
  task automatic wait_valid(output int edges);
    edges = -1;
    for (int j = 0; j < 40; j++) begin
      @(posedge clk); #1;
      if (color_valid === 1'b1) begin
        edges = j;
        break;
      end
    end
  endtask

  task automatic wait_error(input logic lvl, output int edges, output logic saw_valid);
    edges = -1;
    saw_valid = 1'b0;
    for (int j = 0; j < 40; j++) begin
      @(posedge clk); #1;
      if (color_valid === 1'b1) saw_valid = 1'b1;
      if (error === lvl) begin
        edges = j;
        break;
      end
    end
  endtask

  task automatic check_latency(input string name, input int got);
    n_checks++;
    if (got !== LAT) begin
      n_fail++;
      $display("FAIL %s: got latency=%0d edges, required %0d", name, got, LAT);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    sw = 3'b000;
    color_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({color, color_valid, error} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_hold: got color=%b valid=%b error=%b, required 000/0/0",
                 color, color_valid, error);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({color, color_valid, error} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_release_idle: got color=%b valid=%b error=%b, required 000/0/0",
                 color, color_valid, error);
      end
    end
  endtask

  task automatic test_clean_change;
    int e;
    @(negedge clk);
    color_ready = 1'b1;
    exp_q.push_back(3'b001);
    sw = 3'b001;
    wait_valid(e);
    check_latency("clean_latency", e);
    n_checks++;
    if (color !== 3'b001) begin
      n_fail++;
      $display("FAIL clean_color: got %b, required 001", color);
    end
    @(posedge clk); #1;
    n_checks++;
    if (color_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_one_cycle: got valid=%b, required 0", color_valid);
    end
  endtask

  task automatic test_bounce;
    int e;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      sw = i[0] ? 3'b010 : 3'b000;
      repeat (2) @(negedge clk);
    end
    exp_q.push_back(3'b010);
    sw = 3'b010;
    wait_valid(e);
    check_latency("bounce_latency", e);
    n_checks++;
    if (color !== 3'b010) begin
      n_fail++;
      $display("FAIL bounce_color: got %b, required 010", color);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (color_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL bounce_single_event: got valid=%b, required 0", color_valid);
      end
    end
  endtask

  task automatic test_newest_wins;
    int e;
    @(negedge clk);
    color_ready = 1'b0;
    exp_q.push_back(3'b100);
    sw = 3'b100;
    wait_valid(e);
    check_latency("pend_latency", e);
    @(negedge clk);
    repeat (10) @(negedge clk);
    sw = 3'b001;
    repeat (10) @(negedge clk);
    exp_q.push_back(3'b010);
    sw = 3'b010;
    repeat (10) @(negedge clk);
    n_checks++;
    if (color !== 3'b100 || color_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pend_hold: got color=%b valid=%b, required 100/1", color, color_valid);
    end
    color_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (color !== 3'b010 || color_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL back_to_back: got color=%b valid=%b, required 010/1", color, color_valid);
    end
    @(posedge clk); #1;
    n_checks++;
    if (color_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL pend_drain: got valid=%b, required 0", color_valid);
    end
  endtask

  task automatic test_error;
    int   e;
    logic sv;
    @(negedge clk);
    color_ready = 1'b1;
    exp_q.push_back(3'b001);
    sw = 3'b001;
    wait_valid(e);
    check_latency("err_setup_latency", e);
    @(negedge clk);
    sw = 3'b011;
    wait_error(1'b1, e, sv);
    check_latency("err_rise_latency", e);
    @(negedge clk);
    sw = 3'b001;
    wait_error(1'b0, e, sv);
    check_latency("err_fall_latency", e);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (color_valid === 1'b1) sv = 1'b1;
    end
    n_checks++;
    if (sv !== 1'b0) begin
      n_fail++;
      $display("FAIL err_no_event: got valid seen=%b, required 0", sv);
    end
  endtask

  task automatic test_reset_pend;
    int e;
    @(negedge clk);
    color_ready = 1'b0;
    sw = 3'b100;
    wait_valid(e);
    check_latency("rst_pend_latency", e);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    sw = 3'b010;
    #1;
    n_checks++;
    if ({color, color_valid, error} !== 5'b0) begin
      n_fail++;
      $display("FAIL async_reset: got color=%b valid=%b error=%b, required 000/0/0",
               color, color_valid, error);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_valid(e);
    check_latency("post_reset_latency", e);
    n_checks++;
    if (color !== 3'b010) begin
      n_fail++;
      $display("FAIL post_reset_color: got %b, required 010", color);
    end
    exp_q.push_back(3'b010);
    @(negedge clk);
    color_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (color_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_drain: got valid=%b, required 0", color_valid);
    end
  endtask

  initial begin
    test_reset();
    test_clean_change();
    test_bounce();
    test_newest_wins();
    test_error();
    test_reset_pend();
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drained: got %0d colours outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
